// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
//   Shared definitions for the register scoreboard:
//   - ADDR_W_DEF / MAX_LAT_DEF : parameter defaults
//   - cnt_w()                  : counter width needed to hold 0..MAX_LAT
//   - stall_cause_e            : reason the instruction in ID is held
package reg_scoreboard_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int MAX_LAT_DEF = 8;

  function automatic int cnt_w(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_RAW  = 2'd1,
    CAUSE_WAW  = 2'd2,
    CAUSE_PORT = 2'd3
  } stall_cause_e;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// sb_entry
//   One scoreboard slot: cycles remaining until the pending result of a
//   single architectural register is written back.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load, load_val start a new pending result of load_val cycles
//   cnt            cycles remaining (0 = nothing pending)
//   busy           cnt != 0
//   done           cnt == 1, the writeback completes at the end of this cycle
module sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = cnt_w(MAX_LAT_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done
);

  // NOTE: state registers use non-blocking assignments so every slot samples
  // the same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load) begin
      // A fresh issue to this register replaces the old countdown.
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Per-register writeback countdown for the ID stage. Decides whether the
//   instruction in ID must stall (RAW, WAW, or writeback-port conflict) and
//   predicts which register the single writeback port completes this cycle.
// Build option:
//   REG_SCOREBOARD_FWD_EN  defined: a source in its last cycle before
//                          writeback is bypassed, so it does not stall.
//                          undefined: any pending source stalls.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   issue_*_i                instruction in ID (sources, destination, latency)
//   flush_i                  kill the instruction in ID this cycle
//   stall_o                  hold PC/IF_ID, bubble into ID_EX
//   issue_ok_o               instruction leaves ID this cycle
//   busy_o                   per-register pending flag
//   wb_valid_o, wb_rd_o      tracked writeback completing this cycle
//   stall_cause_o            debug: first stall reason (stall_cause_e)
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int CNT_W   = cnt_w(MAX_LAT)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rs_i,
  input  logic [ADDR_W-1:0] issue_rt_i,
  input  logic              issue_rs_use_i,
  input  logic              issue_rt_use_i,
  input  logic              issue_wr_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic [CNT_W-1:0]  issue_lat_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              issue_ok_o,
  output logic [NREG-1:0]   busy_o,
  output logic              wb_valid_o,
  output logic [ADDR_W-1:0] wb_rd_o,
  output logic [1:0]        stall_cause_o
);

  localparam int NSLOT = 2 ** ADDR_W;

`ifdef REG_SCOREBOARD_FWD_EN
  localparam int THR = 1;
`else
  localparam int THR = 0;
`endif

  // Padded to the full address space so any register address indexes safely;
  // slot 0 and slots beyond NREG read as idle.
  logic [CNT_W-1:0] cnt [NSLOT];
  logic [NREG-1:1]  done;
  logic [CNT_W-1:0] lat_eff;
  logic             raw_stall;
  logic             waw_stall;
  logic             port_stall;
  logic             accept;
  stall_cause_e     cause;

  always_comb begin
    if (issue_lat_i == '0) begin
      lat_eff = CNT_W'(1);
    end else if (int'(issue_lat_i) > MAX_LAT) begin
      lat_eff = CNT_W'(MAX_LAT);
    end else begin
      lat_eff = issue_lat_i;
    end
  end

  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    raw_stall  = 1'b0;
    waw_stall  = 1'b0;
    port_stall = 1'b0;
    if (issue_rs_use_i && issue_rs_i != '0 && int'(cnt[issue_rs_i]) > THR)
      raw_stall = 1'b1;
    if (issue_rt_use_i && issue_rt_i != '0 && int'(cnt[issue_rt_i]) > THR)
      raw_stall = 1'b1;
    if (issue_wr_i && issue_rd_i != '0) begin
      waw_stall = (cnt[issue_rd_i] > lat_eff);
      // Counters decrement before the new entry lands, so a neighbour at
      // lat_eff+1 would retire on the same edge as the new result.
      for (int r = 1; r < NREG; r++) begin
        if (ADDR_W'(r) != issue_rd_i &&
            {1'b0, cnt[r]} == ({1'b0, lat_eff} + (CNT_W+1)'(1)))
          port_stall = 1'b1;
      end
    end
  end

  always_comb begin
    stall_o    = ~rst_i & issue_valid_i & (raw_stall | waw_stall | port_stall);
    issue_ok_o = ~rst_i & issue_valid_i & ~(raw_stall | waw_stall | port_stall) & ~flush_i;
    accept     = issue_ok_o & issue_wr_i & (issue_rd_i != '0);
  end

  always_comb begin
    cause = CAUSE_NONE;
    if (stall_o) begin
      if (raw_stall)      cause = CAUSE_RAW;
      else if (waw_stall) cause = CAUSE_WAW;
      else                cause = CAUSE_PORT;
    end
    stall_cause_o = cause;
  end

  // NOTE: the counters sit in flops, not a RAM, so each one is cleared by the
  // synchronous reset; discarding in-flight entries depends on it.
  for (genvar r = 0; r < NSLOT; r++) begin : g_slot
    if (r == 0) begin : g_zero
      assign cnt[r]    = '0;
      assign busy_o[0] = 1'b0;
    end else if (r < NREG) begin : g_entry
      sb_entry #(.CNT_W(CNT_W)) u_entry (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (accept && issue_rd_i == ADDR_W'(r)),
        .load_val (lat_eff),
        .cnt      (cnt[r]),
        .busy     (busy_o[r]),
        .done     (done[r])
      );
    end else begin : g_pad
      assign cnt[r] = '0;
    end
  end

  // Writeback priority encoder: lowest register wins if the port rule is
  // ever bypassed.
  always_comb begin
    wb_valid_o = 1'b0;
    wb_rd_o    = '0;
    for (int r = NREG - 1; r >= 1; r--) begin
      if (done[r]) begin
        wb_valid_o = 1'b1;
        wb_rd_o    = ADDR_W'(r);
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
//   Drives directed scenarios, then random traffic, into reg_scoreboard.
//   The reference model records, per register, the absolute cycle in which
//   its writeback is due; every observable is derived from that and the
//   current cycle number. Honors REG_SCOREBOARD_FWD_EN like the design.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int NREG    = 32;
  localparam int ADDR_W  = 5;
  localparam int MAX_LAT = 8;
  localparam int CNT_W   = cnt_w(MAX_LAT);
`ifdef REG_SCOREBOARD_FWD_EN
  localparam int THR = 1;
`else
  localparam int THR = 0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              issue_valid_i;
  logic [ADDR_W-1:0] issue_rs_i;
  logic [ADDR_W-1:0] issue_rt_i;
  logic              issue_rs_use_i;
  logic              issue_rt_use_i;
  logic              issue_wr_i;
  logic [ADDR_W-1:0] issue_rd_i;
  logic [CNT_W-1:0]  issue_lat_i;
  logic              flush_i;
  logic              stall_o;
  logic              issue_ok_o;
  logic [NREG-1:0]   busy_o;
  logic              wb_valid_o;
  logic [ADDR_W-1:0] wb_rd_o;
  logic [1:0]        stall_cause_o;

  reg_scoreboard #(.NREG(NREG), .ADDR_W(ADDR_W), .MAX_LAT(MAX_LAT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_rs_i     (issue_rs_i),
    .issue_rt_i     (issue_rt_i),
    .issue_rs_use_i (issue_rs_use_i),
    .issue_rt_use_i (issue_rt_use_i),
    .issue_wr_i     (issue_wr_i),
    .issue_rd_i     (issue_rd_i),
    .issue_lat_i    (issue_lat_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .issue_ok_o     (issue_ok_o),
    .busy_o         (busy_o),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_o        (wb_rd_o),
    .stall_cause_o  (stall_cause_o)
  );

  always #5 clk_i = ~clk_i;

  int     passed = 0;
  int     total  = 0;
  longint due [NREG];     // cycle in which wb_valid_o shows r; -1 = none
  longint now    = 0;     // current cycle number
  logic   exp_ok = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
  endtask

  function automatic int lat_eff_m(input int l);
    if (l == 0) return 1;
    if (l > MAX_LAT) return MAX_LAT;
    return l;
  endfunction

  // Cycles left before register r is written back (0 = nothing pending).
  function automatic longint rem(input int r);
    if (r == 0 || due[r] < now) return 0;
    return due[r] - now + 1;
  endfunction

  task automatic drive(input logic v, input int rs, input int rt, input logic rsu,
                       input logic rtu, input logic wr, input int rd, input int lat,
                       input logic fl);
    issue_valid_i  = v;
    issue_rs_i     = ADDR_W'(rs);
    issue_rt_i     = ADDR_W'(rt);
    issue_rs_use_i = rsu;
    issue_rt_use_i = rtu;
    issue_wr_i     = wr;
    issue_rd_i     = ADDR_W'(rd);
    issue_lat_i    = CNT_W'(lat);
    flush_i        = fl;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Compare every output against the model, mid-cycle.
  task automatic eval();
    logic [NREG-1:0] eb;
    logic            ev;
    int              erd;
    logic            raw, waw, port, es;
    int              le;
    int              ec;
    @(negedge clk_i);
    eb  = '0;
    ev  = 1'b0;
    erd = 0;
    for (int r = NREG - 1; r >= 1; r--) begin
      if (rem(r) > 0) eb[r] = 1'b1;
      if (rem(r) == 1) begin
        ev  = 1'b1;
        erd = r;
      end
    end
    le   = lat_eff_m(int'(issue_lat_i));
    raw  = (issue_rs_use_i && issue_rs_i != 0 && rem(int'(issue_rs_i)) > THR) ||
           (issue_rt_use_i && issue_rt_i != 0 && rem(int'(issue_rt_i)) > THR);
    waw  = issue_wr_i && issue_rd_i != 0 && rem(int'(issue_rd_i)) > le;
    port = 1'b0;
    if (issue_wr_i && issue_rd_i != 0)
      for (int r = 1; r < NREG; r++)
        if (r != int'(issue_rd_i) && rem(r) == le + 1) port = 1'b1;
    es     = !rst_i && issue_valid_i && (raw || waw || port);
    exp_ok = !rst_i && issue_valid_i && !(raw || waw || port) && !flush_i;
    ec     = !es ? 0 : raw ? 1 : waw ? 2 : 3;
    check("stall_o", stall_o, es);
    check("issue_ok_o", issue_ok_o, exp_ok);
    check("busy_o", busy_o, eb);
    check("wb_valid_o", wb_valid_o, ev);
    check("wb_rd_o", wb_rd_o, erd);
    check("stall_cause_o", stall_cause_o, ec);
  endtask

  // Advance one edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk_i);
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) due[r] = -1;
    end else if (exp_ok && issue_wr_i && issue_rd_i != 0) begin
      due[issue_rd_i] = now + lat_eff_m(int'(issue_lat_i));
    end
    now++;
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < MAX_LAT + 2; i++) begin
      eval();
      tick();
    end
  endtask

  function automatic int pick_reg();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, NREG - 1));
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    int  stalls;
    logic fin;
    for (int r = 0; r < NREG; r++) due[r] = -1;
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state.
    eval();
    check("reset_busy", busy_o, 0);
    check("reset_wb_valid", wb_valid_o, 0);
    check("reset_stall", stall_o, 0);
    tick();

    // rd=5, lat=3: busy in cycles 1..3, writeback in cycle 3, clear in 4.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 3, 1'b0);
    eval();
    check("t1_issue_ok", issue_ok_o, 1);
    tick();
    idle();
    for (int c = 1; c <= 4; c++) begin
      eval();
      check($sformatf("t1_busy5_c%0d", c), busy_o[5], (c <= 3));
      check($sformatf("t1_wb_valid_c%0d", c), wb_valid_o, (c == 3));
      if (c == 3) check("t1_wb_rd", wb_rd_o, 5);
      tick();
    end

    // ALU-to-ALU chain through rd=8, lat=1.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8, 1, 1'b0);
    eval();
    tick();
    drive(1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0);
    stalls = 0;
    fin    = 1'b0;
    for (int c = 0; c < 6 && !fin; c++) begin
      eval();
      if (issue_ok_o) fin = 1'b1;
      else if (stall_o) stalls++;
      tick();
    end
    check("t2_issued", fin, 1);
    check("t2_stall_cycles", stalls, (THR == 1) ? 0 : 1);
    drain();

    // WAW: rd=4 lat=4, then rd=4 lat=1 presented the next cycle. The old
    // count reads 4,3,2 while it exceeds lat_eff=1, so three held cycles.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 4, 4, 1'b0);
    eval();
    tick();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 4, 1, 1'b0);
    stalls = 0;
    fin    = 1'b0;
    for (int c = 0; c < 8 && !fin; c++) begin
      eval();
      if (c == 0) check("t3_cause", stall_cause_o, CAUSE_WAW);
      if (issue_ok_o) fin = 1'b1;
      else if (stall_o) stalls++;
      tick();
    end
    check("t3_issued", fin, 1);
    check("t3_stall_cycles", stalls, 3);
    drain();

    // Port: rd=3 lat=3, then rd=6 lat=2 would retire on the same edge.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0);
    eval();
    tick();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 6, 2, 1'b0);
    eval();
    check("t4_port_stall", stall_o, 1);
    check("t4_cause", stall_cause_o, CAUSE_PORT);
    tick();
    eval();
    check("t4_accept", issue_ok_o, 1);
    tick();
    idle();
    eval();
    check("t4_wb_first", wb_rd_o, 3);
    tick();
    eval();
    check("t4_wb_second", wb_rd_o, 6);
    tick();
    drain();

    // Register 0 never tracked; lat 0 acts as lat 1.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 5, 1'b0);
    eval();
    check("t5_rd0_ok", issue_ok_o, 1);
    tick();
    idle();
    eval();
    check("t5_rd0_busy", busy_o, 0);
    tick();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 0, 1'b0);
    eval();
    tick();
    idle();
    eval();
    check("t5_lat0_busy", busy_o[9], 1);
    check("t5_lat0_wb_rd", wb_rd_o, 9);
    tick();
    eval();
    check("t5_lat0_clear", busy_o[9], 0);
    tick();
    drain();

    // Flush kills a legal issue.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 7, 2, 1'b1);
    eval();
    check("t6_flush_ok", issue_ok_o, 0);
    tick();
    idle();
    eval();
    check("t6_flush_busy", busy_o, 0);
    tick();

    // Reset with three entries in flight.
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 10, 8, 1'b0);
    eval();
    tick();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 11, 5, 1'b0);
    eval();
    tick();
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 12, 2, 1'b0);
    eval();
    tick();
    idle();
    rst_i = 1'b1;
    eval();
    check("t7_pending", busy_o[12:10], 3'b111);
    tick();
    rst_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      eval();
      check($sformatf("t7_busy_c%0d", c), busy_o, 0);
      check($sformatf("t7_wb_c%0d", c), wb_valid_o, 0);
      tick();
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, pick_reg(), pick_reg(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, pick_reg(),
            int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
      eval();
      tick();
    end
    rst_i = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
